counter_bank: RTL and testbench

//   Multi-channel event counter bank with atomic snapshot and registered readout.

---
 rtl/counter_bank.sv | 120 ++++++++++++
 tb/tb_counter_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// Multi-channel event counter bank: per-channel wrap/saturate counters with sticky
// overflow, a one-cycle atomic snapshot into shadow registers, and a registered read port.

module counter_bank_lane #(
  parameter int N_cnt    = 32,
  parameter int SAT      = 0,
  parameter int SNAP_CLR = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic             ovf,
  output logic [N_cnt-1:0] shadow,
  output logic             shadow_ovf
);
  logic [N_cnt-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      ovf        <= 1'b0;
      shadow     <= '0;
      shadow_ovf <= 1'b0;
    end else begin
      // shadow captures the pre-clear, pre-increment value
      if (snap) begin
        shadow     <= cnt;
        shadow_ovf <= ovf;
      end
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (snap && (SNAP_CLR != 0)) begin
        cnt <= N_cnt'(inc);
        ovf <= 1'b0;
      end else if (inc) begin
        if (&cnt) begin
          ovf <= 1'b1;
          cnt <= (SAT != 0) ? cnt : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module counter_bank #(
  parameter int N_ch     = 4,
  parameter int N_cnt    = 32,
  parameter int SEL_W    = 2,
  parameter int SAT      = 0,
  parameter int SNAP_CLR = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_ch-1:0]  inc,
  input  logic [N_ch-1:0]  clr,
  input  logic             snap,
  output logic             snap_done,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [N_cnt-1:0] rd_data,
  output logic             rd_ovf,
  output logic             rd_valid,
  output logic [N_ch-1:0]  ovf
);
  localparam int N_SEL = 2**SEL_W;

  logic [N_ch-1:0][N_cnt-1:0]  shadow;
  logic [N_ch-1:0]             shadow_ovf;
  logic [N_SEL-1:0][N_cnt-1:0] sh_pad;
  logic [N_SEL-1:0]            ov_pad;
  logic [1:0]                  vld_pipe;

  for (genvar g = 0; g < N_ch; g++) begin : g_lane
    counter_bank_lane #(.N_cnt(N_cnt), .SAT(SAT), .SNAP_CLR(SNAP_CLR)) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .inc        (inc[g]),
      .clr        (clr[g]),
      .snap       (snap),
      .ovf        (ovf[g]),
      .shadow     (shadow[g]),
      .shadow_ovf (shadow_ovf[g])
    );
  end

  // selects past the last channel read back as zero
  for (genvar g = 0; g < N_SEL; g++) begin : g_pad
    if (g < N_ch) begin : g_live
      assign sh_pad[g] = shadow[g];
      assign ov_pad[g] = shadow_ovf[g];
    end else begin : g_zero
      assign sh_pad[g] = '0;
      assign ov_pad[g] = 1'b0;
    end
  end

  assign vld_pipe[0] = rd_en;
  assign rd_valid    = vld_pipe[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[1] <= 1'b0;
      rd_data     <= '0;
      rd_ovf      <= 1'b0;
      snap_done   <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      snap_done   <= snap;
      if (rd_en) begin
        rd_data <= sh_pad[rd_sel];
        rd_ovf  <= ov_pad[rd_sel];
      end
    end
  end
endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: three configurations driven in lockstep, checked every cycle
// against an array-based behavioural model, plus directed literal expectations.

module tb_counter_bank;
  localparam int NI = 3;
  // instance 0: defaults; 1: 3ch/4b wrap snap-clear; 2: 3ch/4b saturate no snap-clear
  int nch  [NI] = '{4, 3, 3};
  int ncnt [NI] = '{32, 4, 4};
  int satm [NI] = '{0, 0, 1};
  int sclr [NI] = '{1, 1, 0};

  logic       clock, reset_n;
  logic [3:0] inc, clr;
  logic       snap, rd_en;
  logic [1:0] rd_sel;

  logic [31:0] rd_data_a;
  logic [3:0]  rd_data_b, rd_data_c, ovf_a;
  logic [2:0]  ovf_b, ovf_c;
  logic        rd_ovf_a, rd_ovf_b, rd_ovf_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic        snap_done_a, snap_done_b, snap_done_c;

  counter_bank u_a (
    .clock(clock), .reset_n(reset_n), .inc(inc), .clr(clr), .snap(snap),
    .snap_done(snap_done_a), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_a),
    .rd_ovf(rd_ovf_a), .rd_valid(rd_valid_a), .ovf(ovf_a));

  counter_bank #(.N_ch(3), .N_cnt(4), .SEL_W(2), .SAT(0), .SNAP_CLR(1)) u_b (
    .clock(clock), .reset_n(reset_n), .inc(inc[2:0]), .clr(clr[2:0]), .snap(snap),
    .snap_done(snap_done_b), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_b),
    .rd_ovf(rd_ovf_b), .rd_valid(rd_valid_b), .ovf(ovf_b));

  counter_bank #(.N_ch(3), .N_cnt(4), .SEL_W(2), .SAT(1), .SNAP_CLR(0)) u_c (
    .clock(clock), .reset_n(reset_n), .inc(inc[2:0]), .clr(clr[2:0]), .snap(snap),
    .snap_done(snap_done_c), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_c),
    .rd_ovf(rd_ovf_c), .rd_valid(rd_valid_c), .ovf(ovf_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state
  longint unsigned m_cnt [NI][4];
  bit              m_ovf [NI][4];
  longint unsigned s_cnt [NI][4];
  bit              s_ovf [NI][4];
  longint unsigned m_rd  [NI];
  bit              m_ro  [NI];
  bit              m_rv  [NI];
  bit              m_sd  [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_cnt[k][c] = 0; m_ovf[k][c] = 0; s_cnt[k][c] = 0; s_ovf[k][c] = 0;
      end
      m_rd[k] = 0; m_ro[k] = 0; m_rv[k] = 0; m_sd[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      longint unsigned mx;
      mx = (64'd1 << ncnt[k]) - 1;
      // read sees the shadow as it was before this cycle's snapshot
      m_rv[k] = rd_en;
      if (rd_en) begin
        if (int'(rd_sel) < nch[k]) begin
          m_rd[k] = s_cnt[k][rd_sel]; m_ro[k] = s_ovf[k][rd_sel];
        end else begin
          m_rd[k] = 0; m_ro[k] = 0;
        end
      end
      m_sd[k] = snap;
      for (int c = 0; c < nch[k]; c++) begin
        if (snap) begin
          s_cnt[k][c] = m_cnt[k][c]; s_ovf[k][c] = m_ovf[k][c];
        end
        if (clr[c]) begin
          m_cnt[k][c] = 0; m_ovf[k][c] = 0;
        end else if (snap && sclr[k] != 0) begin
          m_cnt[k][c] = inc[c] ? 1 : 0; m_ovf[k][c] = 0;
        end else if (inc[c]) begin
          if (m_cnt[k][c] == mx) begin
            m_ovf[k][c] = 1;
            m_cnt[k][c] = (satm[k] != 0) ? mx : 0;
          end else begin
            m_cnt[k][c] = m_cnt[k][c] + 1;
          end
        end
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  task automatic cmp(input int k, input longint unsigned d, input bit ro, input bit rv,
                     input bit sd, input longint unsigned ov);
    longint unsigned eo;
    eo = 0;
    for (int c = 0; c < nch[k]; c++) if (m_ovf[k][c]) eo |= (64'd1 << c);
    chk($sformatf("inst%0d.rd_data", k), d, m_rd[k]);
    chk($sformatf("inst%0d.rd_ovf", k), 64'(ro), 64'(m_ro[k]));
    chk($sformatf("inst%0d.rd_valid", k), 64'(rv), 64'(m_rv[k]));
    chk($sformatf("inst%0d.snap_done", k), 64'(sd), 64'(m_sd[k]));
    chk($sformatf("inst%0d.ovf", k), ov, eo);
  endtask

  always @(negedge clock) begin
    cmp(0, 64'(rd_data_a), rd_ovf_a, rd_valid_a, snap_done_a, 64'(ovf_a));
    cmp(1, 64'(rd_data_b), rd_ovf_b, rd_valid_b, snap_done_b, 64'(ovf_b));
    cmp(2, 64'(rd_data_c), rd_ovf_c, rd_valid_c, snap_done_c, 64'(ovf_c));
  end

  task automatic tick(input logic [3:0] i, input logic [3:0] c, input logic s,
                      input logic re, input logic [1:0] rs);
    inc = i; clr = c; snap = s; rd_en = re; rd_sel = rs;
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    inc = '0; clr = '0; snap = 1'b0; rd_en = 1'b0; rd_sel = '0;
    repeat (2) @(negedge clock);
    chk("reset rd_data", 64'(rd_data_a), 0);
    chk("reset rd_valid", 64'(rd_valid_a), 0);
    chk("reset snap_done", 64'(snap_done_a), 0);
    chk("reset ovf", 64'(ovf_a), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // count ten events then snapshot and read
    repeat (10) tick(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0);
    tick(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    chk("snap_done pulse", 64'(snap_done_a), 1);
    tick(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    chk("count read data", 64'(rd_data_a), 10);
    chk("count read ovf", 64'(rd_ovf_a), 0);
    chk("count read valid", 64'(rd_valid_a), 1);
    tick(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    tick(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    chk("live cleared by snap", 64'(rd_data_a), 0);
    chk("no snap-clear keeps live", 64'(rd_data_c), 10);

    // wrap vs saturate on 4-bit counters
    tick(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    repeat (17) tick(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
    chk("wrap live ovf", 64'(ovf_b[0]), 1);
    tick(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    chk("snap clears ovf", 64'(ovf_b[0]), 0);
    chk("no snap-clear keeps ovf", 64'(ovf_c[0]), 1);
    tick(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);
    chk("wrap shadow", 64'(rd_data_b), 1);
    chk("wrap shadow ovf", 64'(rd_ovf_b), 1);
    chk("sat shadow", 64'(rd_data_c), 15);
    chk("sat shadow ovf", 64'(rd_ovf_c), 1);
    chk("wide no wrap", 64'(rd_data_a), 17);

    // snapshot with a coincident event; read with snap returns old shadow
    tick(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    repeat (7) tick(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0);
    tick(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0);
    tick(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2);
    chk("read with snap old shadow", 64'(rd_data_a), 7);
    tick(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);
    chk("event kept across snap", 64'(rd_data_a), 1);
    tick(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    chk("idle rd_valid", 64'(rd_valid_a), 0);
    chk("idle rd_data holds", 64'(rd_data_a), 1);

    // clear beats increment and snapshot-clear; shadow gets the pre-clear value
    tick(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    repeat (9) tick(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
    tick(4'b1000, 4'b1000, 1'b1, 1'b0, 2'd0);
    chk("clr ovf3", 64'(ovf_a[3]), 0);
    tick(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3);
    chk("clr shadow pre-clear", 64'(rd_data_a), 9);
    chk("out-of-range data", 64'(rd_data_b), 0);
    chk("out-of-range valid", 64'(rd_valid_b), 1);
    tick(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    tick(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3);
    chk("clr drops inc", 64'(rd_data_a), 0);

    // asynchronous reset mid-operation
    tick(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    repeat (17) tick(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
    tick(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0);
    inc = '0; clr = '0; snap = 1'b0; rd_en = 1'b0;
    chk("pre-reset ovf", 64'(ovf_c[0]), 1);
    chk("pre-reset valid", 64'(rd_valid_a), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset ovf", 64'(ovf_c), 0);
    chk("async reset snap_done", 64'(snap_done_a), 0);
    chk("async reset rd_valid", 64'(rd_valid_a), 0);
    chk("async reset rd_data", 64'(rd_data_c), 0);
    #1 reset_n = 1'b1;
    @(negedge clock);

    // randomized traffic, event-heavy so the 4-bit counters wrap often
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ri, rc;
      for (int b = 0; b < 4; b++) begin
        ri[b] = ($urandom_range(3) != 0);
        rc[b] = ($urandom_range(31) == 0);
      end
      tick(ri, rc, $urandom_range(7) == 0, $urandom_range(1) == 1, 2'($urandom_range(3)));
    end
    tick(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
